// File: rtl/sockit_spi_fifo_if.sv
// Valid/ready handshake bundle for sockit_spi_fifo: input (drain) side and output (source) side.
// The slave modport is the FIFO's view; master is the producer/consumer view.
interface sockit_spi_fifo_if #(
  parameter int DW = 32
);
  logic          i_vld;
  logic [DW-1:0] i_dat;
  logic          i_rdy;
  logic          o_vld;
  logic [DW-1:0] o_dat;
  logic          o_rdy;

  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat
  );

  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat
  );
endinterface

// File: rtl/sockit_spi_fifo.sv
// Synchronous first-word-fall-through valid/ready FIFO for the SPI master data/command paths.
// Optional zero-latency pass-through when empty: define SOCKIT_SPI_FIFO_BYPASS_EN.
module sockit_spi_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  sockit_spi_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_o_vld;
  logic [DW-1:0] w_o_dat;
  logic          w_i_trn;
  logic          w_o_trn;
  logic          w_wr;
  logic          w_rd;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Ready depends only on occupancy, so upstream never sees a path from o_rdy.
  assign bus.i_rdy = !w_full;
  assign w_i_trn   = bus.i_vld & !w_full;
  assign w_o_trn   = w_o_vld & bus.o_rdy;

`ifdef SOCKIT_SPI_FIFO_BYPASS_EN
  logic w_byp;
  logic w_pass;
  assign w_byp   = w_empty & bus.i_vld;
  assign w_pass  = w_byp & bus.o_rdy;
  assign w_o_vld = !w_empty | bus.i_vld;
  assign w_o_dat = w_byp ? bus.i_dat : r_mem[r_rp];
  assign w_wr    = w_i_trn & !w_pass;
  assign w_rd    = w_o_trn & !w_pass;
`else
  assign w_o_vld = !w_empty;
  assign w_o_dat = r_mem[r_rp];
  assign w_wr    = w_i_trn;
  assign w_rd    = w_o_trn;
`endif

  assign bus.o_vld = w_o_vld;
  assign bus.o_dat = w_o_dat;
  assign cnt       = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // NOTE: storage has no reset; contents are only visible once cnt says they are valid.
  always_ff @(posedge clk) begin
    if (rst && !clr && w_wr) r_mem[r_wp] <= bus.i_dat;
  end

endmodule

// File: tb/tb_sockit_spi_fifo.sv
// Self-checking bench for sockit_spi_fifo: queue-based model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sockit_spi_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [2:0] cnt;

  sockit_spi_fifo_if #(.DW(DW)) bus ();

  sockit_spi_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus),
    .cnt (cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [DW-1:0] mq   [$];  // model contents
  logic [DW-1:0] dlog [$];  // words the DUT actually delivered

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a plain queue updated by the handshake rules.
  always @(posedge clk) begin
    int n;
    n = mq.size();
    if (!rst || clr) begin
      mq.delete();
    end else begin
`ifdef SOCKIT_SPI_FIFO_BYPASS_EN
      if (!(n == 0 && bus.i_vld && bus.o_rdy)) begin
`else
      begin
`endif
        if (n != 0 && bus.o_rdy) void'(mq.pop_front());
        if (n != DEPTH && bus.i_vld) mq.push_back(bus.i_dat);
      end
    end
  end

  always @(posedge clk) begin
    if (rst && !clr && bus.o_vld && bus.o_rdy) dlog.push_back(bus.o_dat);
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    int            n;
    logic          e_vld;
    logic [DW-1:0] e_dat;
    if (chk_en) begin
      n     = mq.size();
      e_vld = (n != 0);
      e_dat = (n != 0) ? mq[0] : '0;
`ifdef SOCKIT_SPI_FIFO_BYPASS_EN
      if (n == 0 && bus.i_vld) begin
        e_vld = 1'b1;
        e_dat = bus.i_dat;
      end
`endif
      check("cmp_i_rdy", 32'(bus.i_rdy), 32'(n != DEPTH));
      check("cmp_o_vld", 32'(bus.o_vld), 32'(e_vld));
      if (e_vld) check("cmp_o_dat", bus.o_dat, e_dat);
      check("cmp_cnt", 32'(cnt), 32'(n));
    end
  end

  initial begin
    logic [DW-1:0] fd_exp [5];
    fd_exp[0] = 32'h11; fd_exp[1] = 32'h22; fd_exp[2] = 32'h33;
    fd_exp[3] = 32'h44; fd_exp[4] = 32'h55;

    // Reset held two cycles with a word offered
    rst = 1'b0; clr = 1'b0;
    bus.i_vld = 1'b1; bus.i_dat = 32'h99; bus.o_rdy = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_o_vld", 32'(bus.o_vld), 32'd0);
    check("rst_i_rdy", 32'(bus.i_rdy), 32'd1);
    check("rst_cnt", 32'(cnt), 32'd0);
    rst = 1'b1; bus.i_vld = 1'b0;
    tick();
    check("rst_nostore_cnt", 32'(cnt), 32'd0);
    check("rst_nostore_vld", 32'(bus.o_vld), 32'd0);

    // Fill with o_rdy low, fifth word held off
    dlog.delete();
    bus.i_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.i_dat = fd_exp[k];
      tick();
    end
    check("fill_cnt4", 32'(cnt), 32'd4);
    check("fill_i_rdy", 32'(bus.i_rdy), 32'd0);
    check("fill_head", bus.o_dat, 32'h11);
    bus.i_dat = 32'h55;
    tick();
    tick();
    check("full_hold_cnt", 32'(cnt), 32'd4);
    check("full_hold_i_rdy", 32'(bus.i_rdy), 32'd0);

    // Full with simultaneous read: read only, then read+write
    bus.o_rdy = 1'b1;
    tick();
    check("full_rd_cnt3", 32'(cnt), 32'd3);
    check("full_rd_i_rdy", 32'(bus.i_rdy), 32'd1);
    tick();
    check("rdwr_cnt3", 32'(cnt), 32'd3);
    bus.i_vld = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("drain_cnt0", 32'(cnt), 32'd0);
    check("drain_len", 32'(dlog.size()), 32'd5);
    for (int k = 0; k < 5 && k < dlog.size(); k++) check("drain_order", dlog[k], fd_exp[k]);

    // Streaming 16 words across pointer wrap
    dlog.delete();
    bus.o_rdy = 1'b1; bus.i_vld = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.i_dat = 32'h100 + 32'(k);
      tick();
`ifndef SOCKIT_SPI_FIFO_BYPASS_EN
      check("stream_cnt1", 32'(cnt), 32'd1);
`endif
    end
    bus.i_vld = 1'b0;
    tick();
    check("stream_len", 32'(dlog.size()), 32'd16);
    for (int k = 0; k < 16 && k < dlog.size(); k++) check("stream_order", dlog[k], 32'h100 + 32'(k));
    check("stream_end_cnt", 32'(cnt), 32'd0);

    // Clear with both sides active
    dlog.delete();
    bus.o_rdy = 1'b0; bus.i_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.i_dat = 32'hA1 + 32'(k);
      tick();
    end
    check("clr_pre_cnt", 32'(cnt), 32'd3);
    clr = 1'b1; bus.o_rdy = 1'b1; bus.i_dat = 32'hEE;
    tick();
    clr = 1'b0; bus.i_vld = 1'b0;
    check("clr_cnt", 32'(cnt), 32'd0);
    check("clr_o_vld", 32'(bus.o_vld), 32'd0);
    check("clr_no_delivery", 32'(dlog.size()), 32'd0);
    tick();
    check("clr_nostore_cnt", 32'(cnt), 32'd0);
    check("clr_nostore_vld", 32'(bus.o_vld), 32'd0);

    // Empty FIFO, single word offered with o_rdy high
    dlog.delete();
    bus.i_vld = 1'b1; bus.i_dat = 32'hA5; bus.o_rdy = 1'b1;
    #1;
`ifdef SOCKIT_SPI_FIFO_BYPASS_EN
    check("byp_same_vld", 32'(bus.o_vld), 32'd1);
    check("byp_same_dat", bus.o_dat, 32'hA5);
    tick();
    bus.i_vld = 1'b0;
    #1;
    check("byp_cnt", 32'(cnt), 32'd0);
    check("byp_after_vld", 32'(bus.o_vld), 32'd0);
`else
    check("nobyp_same_vld", 32'(bus.o_vld), 32'd0);
    tick();
    bus.i_vld = 1'b0;
    #1;
    check("nobyp_next_vld", 32'(bus.o_vld), 32'd1);
    check("nobyp_next_dat", bus.o_dat, 32'hA5);
    check("nobyp_cnt", 32'(cnt), 32'd1);
    tick();
    check("nobyp_drained", 32'(cnt), 32'd0);
`endif
    check("byp_delivered", 32'(dlog.size()), 32'd1);
    if (dlog.size() > 0) check("byp_word", dlog[0], 32'hA5);

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sockit_spi_fifo.md
Name: sockit_spi_fifo

Overview:
- Synchronous valid/ready queue buffer for the SPI master data and command paths.
- Input side is a handshake drain: it accepts words from an upstream source.
- Output side is a handshake source: it presents words to a downstream drain.
- Decouples producer and consumer (e.g. bus-side register writes vs. serializer), absorbing up to DEPTH words of rate mismatch.

Parameters:
DW, 32, data word width in bits
DEPTH, 4, number of storage entries; power of 2, >= 2
CW, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
clr  input  1  synchronous clear, active-high; empties queue
i_vld  input  1  input valid from upstream source
i_dat  input  DW  input data
i_rdy  output  1  input ready to upstream source
o_vld  output  1  output valid to downstream drain
o_dat  output  DW  output data
o_rdy  input  1  output ready from downstream drain
cnt  output  CW  current occupancy, 0..DEPTH

Behaviour:
- Transfer rules: input transfer i_trn = i_vld & i_rdy; output transfer o_trn = o_vld & o_rdy; data moves only on a transfer.
- Storage: register array mem[DEPTH]; write pointer wp and read pointer rp, each log2(DEPTH) bits, wrap modulo DEPTH naturally.
- Occupancy: cnt register.
- Reset (rst=0 at a clock edge):
  - wp=0, rp=0, cnt=0.
  - Outputs: o_vld=0, i_rdy=1, cnt=0; o_dat don't-care (mem not reset).
- Clear (clr=1, rst=1): same as reset on that edge. Takes precedence over any same-cycle i_trn/o_trn, which are discarded.
- i_rdy = (cnt != DEPTH); combinational from state only, never from i_vld or o_rdy.
- o_vld = (cnt != 0); o_dat = mem[rp] (first-word fall-through, combinational read of registered storage).
- On i_trn: mem[wp] <= i_dat, wp <= wp+1.
- On o_trn: rp <= rp+1.
- cnt update: +1 on i_trn only; -1 on o_trn only; unchanged on both or neither.
- Latency: a word accepted at edge N is presented on o_vld/o_dat after edge N (one cycle), in-order.
- Full (cnt=DEPTH): i_rdy=0, so no write. A simultaneous read frees a slot, but i_rdy rises only the next cycle.
- Empty (cnt=0): o_vld=0. A word written this cycle appears the next cycle; no same-cycle pass-through (except with the optional feature).
- Simultaneous read+write at 0<cnt<DEPTH: both pointers advance, cnt holds.
- o_dat must remain stable while o_vld=1 and o_rdy=0.
- Upstream must hold i_dat stable while i_vld=1 and i_rdy=0; the block does not check this.
- Reset or clr mid-stream: all stored words are lost; no output transfer occurs on that edge.

Optional Feature:
- Macro: SOCKIT_SPI_FIFO_BYPASS_EN.
- Defined:
  - When cnt=0 and i_vld=1, o_vld=1 and o_dat=i_dat combinationally.
  - If o_rdy=1 in that cycle, the word passes through with zero latency: not stored, pointers and cnt unchanged.
  - If o_rdy=0, the word is stored normally.
  - i_rdy is unchanged (still cnt != DEPTH).
- Not defined: behaviour exactly as above, minimum latency one cycle, no combinational path from i_* to o_*.

Test Plan:
- Reset: hold rst=0 two cycles with i_vld=1 -> o_vld=0, i_rdy=1, cnt=0; no word stored after release.
- Fill/drain: DEPTH=4, o_rdy=0, write 0x11,0x22,0x33,0x44,0x55 -> i_rdy=0 after 4th accept, cnt=4, 0x55 held. Then o_rdy=1 -> outputs 0x11..0x44 in order, then 0x55 accepted and output; cnt returns to 0.
- Streaming: i_vld=1, o_rdy=1 continuously, 16 incrementing words -> one word per cycle after a 1-cycle fill, cnt steady at 1, order preserved across pointer wrap.
- Full with simultaneous read: cnt=4, i_vld=1, o_rdy=1 -> cycle 1 read only (cnt=3); cycle 2 read+write (cnt stays 3).
- Clear: cnt=3, assert clr with i_vld=1 and o_rdy=1 -> next cycle cnt=0, o_vld=0; no word delivered or stored on that edge.
- Bypass (macro defined): empty, i_vld=1 with 0xA5, o_rdy=1 -> o_vld=1, o_dat=0xA5 same cycle, cnt stays 0. Macro undefined -> 0xA5 appears next cycle.
